// File: rtl/clk_select_ctrl.sv
// Glitch-free clock mux select sequencer: break-before-make switching between
// NUM_CLOCKS sample clocks with a guard interval and a settle interval.
module clk_select_ctrl #(
  parameter int NUM_CLOCKS    = 4,
  parameter int SEL_W         = 2,
  parameter int GUARD_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [SEL_W-1:0]      req_sel,
  output logic                  req_ready,
  output logic [NUM_CLOCKS-1:0] clk_select,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  cur_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DROP, MAKE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic             accept;
  logic             sel_bad;

  function automatic logic [NUM_CLOCKS-1:0] decode(input logic [SEL_W-1:0] s);
    return NUM_CLOCKS'(1) << s;
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign sel_bad   = 32'(req_sel) >= 32'(NUM_CLOCKS);

  // cnt is loaded with (duration - 1) on entry, so a state ends on the cycle cnt reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= '0;
      clk_select <= '0;
      cur_sel    <= '0;
      cur_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (sel_bad) begin
              err <= 1'b1;
            end else begin
              sel_q <= req_sel;
              busy  <= 1'b1;
              if (cur_valid && (req_sel == cur_sel)) begin
                state   <= DONE;
                done    <= 1'b1;
                cur_sel <= req_sel;
              end else if (!cur_valid) begin
                // mux output already parked: no guard needed
                state      <= MAKE;
                cnt        <= SETTLE_LOAD;
                clk_select <= decode(req_sel);
              end else begin
                state      <= DROP;
                cnt        <= GUARD_LOAD;
                clk_select <= '0;
                cur_valid  <= 1'b0;
              end
            end
          end
        end
        DROP: begin
          if (cnt == '0) begin
            state      <= MAKE;
            cnt        <= SETTLE_LOAD;
            clk_select <= decode(sel_q);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MAKE: begin
          if (cnt == '0) begin
            state     <= DONE;
            cnt       <= '0;
            done      <= 1'b1;
            cur_sel   <= sel_q;
            cur_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The mux must never see two selects at once or a direct hop between clocks
  a_onehot0: assert property (@(posedge clk) $onehot0(clk_select));
  a_no_hop: assert property (@(posedge clk) disable iff (rst)
    ((clk_select != '0) && ($past(clk_select) != '0)) |-> (clk_select == $past(clk_select)));

endmodule

// File: tb/tb_clk_select_ctrl.sv
// Randomized bench for clk_select_ctrl against a timeline-based switch model.
module tb_clk_select_ctrl;

  localparam int NC = 4;
  localparam int SW = 2;
  localparam int G  = 4;
  localparam int S  = 3;
  localparam int K_SAME = 0, K_DIRECT = 1, K_DROP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic          req_ready, cur_valid, busy, done, err;
  logic [NC-1:0] clk_select;
  logic [SW-1:0] cur_sel;

  logic       req_valid3 = 1'b0;
  logic [1:0] req_sel3 = '0;
  logic       req_ready3, cur_valid3, busy3, done3, err3;
  logic [2:0] clk_select3;
  logic [1:0] cur_sel3;

  int checks = 0;
  int failures = 0;

  // switch timeline model
  int cyc = 0;
  bit m_live = 0, m_was_rst = 0, m_err = 0, active = 0;
  bit m_cur_valid = 0;
  int m_cur_sel = 0;
  int sw_t = 0, sw_e = 0, sw_kind = 0, sw_tgt = 0;

  always #5 clk = ~clk;

  clk_select_ctrl #(.NUM_CLOCKS(NC), .SEL_W(SW), .GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .clk_select(clk_select), .cur_sel(cur_sel), .cur_valid(cur_valid), .busy(busy),
    .done(done), .err(err));

  clk_select_ctrl #(.NUM_CLOCKS(3), .SEL_W(2), .GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_sel(req_sel3), .req_ready(req_ready3),
    .clk_select(clk_select3), .cur_sel(cur_sel3), .cur_valid(cur_valid3), .busy(busy3),
    .done(done3), .err(err3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    chk("wait_idle", 32'(busy), 0);
  endtask

  // Cycle c is the cycle following edge c; a switch accepted at the end of cycle T
  // occupies cycles T+1..sw_e and commits at the edge ending sw_e.
  always @(posedge clk) begin
    int  prev, rs;
    bit  in_sw;
    prev = cyc;
    cyc = cyc + 1;
    m_err = 0;
    m_was_rst = 0;
    if (rst) begin
      active = 0; m_cur_valid = 0; m_cur_sel = 0; m_live = 1; m_was_rst = 1;
    end else if (m_live) begin
      in_sw = active;
      if (active && prev == sw_e) begin
        m_cur_sel = sw_tgt; m_cur_valid = 1; active = 0;
      end
      if (!in_sw && req_valid) begin
        rs = int'(req_sel);
        if (rs >= NC) begin
          m_err = 1;
        end else begin
          sw_t = prev; sw_tgt = rs; active = 1;
          if (m_cur_valid && rs == m_cur_sel) begin
            sw_kind = K_SAME;   sw_e = prev + 1;
          end else if (!m_cur_valid) begin
            sw_kind = K_DIRECT; sw_e = prev + S + 1;
          end else begin
            sw_kind = K_DROP;   sw_e = prev + G + S + 1;
          end
        end
      end
    end
  end

  int last_nz = 0;
  int zrun = 0;

  always @(negedge clk) begin
    int c, e_cs, e_cv, e_cur, e_busy, e_done;
    if (m_live) begin
      c = cyc;
      if (active) begin
        e_busy = 1;
        e_done = (c == sw_e) ? 1 : 0;
        e_cs   = (sw_kind == K_DROP && c <= sw_t + G) ? 0 : (1 << sw_tgt);
        e_cv   = (sw_kind == K_SAME || c == sw_e) ? 1 : 0;
        e_cur  = (c == sw_e) ? sw_tgt : m_cur_sel;
      end else begin
        e_busy = 0;
        e_done = 0;
        e_cs   = m_cur_valid ? (1 << m_cur_sel) : 0;
        e_cv   = m_cur_valid ? 1 : 0;
        e_cur  = m_cur_sel;
      end
      chk("busy", 32'(busy), e_busy);
      chk("done", 32'(done), e_done);
      chk("err", 32'(err), m_err ? 1 : 0);
      chk("req_ready", 32'(req_ready), (!active && !rst) ? 1 : 0);
      chk("clk_select", 32'(clk_select), e_cs);
      chk("cur_valid", 32'(cur_valid), e_cv);
      chk("cur_sel", 32'(cur_sel), e_cur);
      // independent safety watch on the mux select
      if (m_was_rst) last_nz = 0;
      chk("onehot0", ($countones(clk_select) <= 1) ? 1 : 0, 1);
      if (clk_select != '0) begin
        if (last_nz != 0 && int'(clk_select) != last_nz) chk("guard_gap", (zrun >= G) ? 1 : 0, 1);
        last_nz = int'(clk_select);
        zrun = 0;
      end else begin
        zrun++;
      end
    end
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_clk_select", 32'(clk_select), 0);
    chk("rst_cur_valid", 32'(cur_valid), 0);
    chk("rst_cur_sel", 32'(cur_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    // out-of-range select on a 3-clock instance
    req_valid3 = 1'b1; req_sel3 = 2'd3;
    tick();
    chk("bad_err", 32'(err3), 1);
    chk("bad_busy", 32'(busy3), 0);
    chk("bad_ready", 32'(req_ready3), 1);
    chk("bad_clk_select", 32'(clk_select3), 0);
    req_sel3 = 2'd1;
    tick();
    req_valid3 = 1'b0;
    chk("bad_err_clear", 32'(err3), 0);
    chk("bad_then_ok", 32'(clk_select3), 32'h2);
    chk("bad_then_busy", 32'(busy3), 1);

    // first request after reset goes straight to MAKE
    req_valid = 1'b1; req_sel = 2'd2;
    tick();
    req_valid = 1'b0;
    chk("s1_clk_select", 32'(clk_select), 32'h4);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_cur_valid", 32'(cur_valid), 0);
    tick(); tick();
    chk("s1_no_done_early", 32'(done), 0);
    tick();
    chk("s1_done", 32'(done), 1);
    chk("s1_cur_sel", 32'(cur_sel), 2);
    chk("s1_cur_valid_done", 32'(cur_valid), 1);
    tick();
    chk("s1_idle", 32'(busy), 0);
    chk("s1_ready", 32'(req_ready), 1);

    // 2 -> 0 with guard interval
    req_valid = 1'b1; req_sel = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("s2_drop", 32'(clk_select), 0);
    chk("s2_cur_valid", 32'(cur_valid), 0);
    repeat (3) tick();
    chk("s2_guard_end", 32'(clk_select), 0);
    tick();
    chk("s2_make", 32'(clk_select), 32'h1);
    chk("s2_busy", 32'(busy), 1);
    repeat (3) tick();
    chk("s2_done", 32'(done), 1);
    chk("s2_cur_sel", 32'(cur_sel), 0);
    tick();
    chk("s2_idle", 32'(busy), 0);

    // same-clock request completes immediately
    req_valid = 1'b1; req_sel = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("s3_done", 32'(done), 1);
    chk("s3_clk_select", 32'(clk_select), 32'h1);
    tick();
    chk("s3_done_clear", 32'(done), 0);
    chk("s3_clk_select_hold", 32'(clk_select), 32'h1);

    // held request with changing select: one acceptance per switch
    req_valid = 1'b1; req_sel = 2'd1;
    tick();
    req_sel = 2'd3;
    chk("s4_ready_busy", 32'(req_ready), 0);
    repeat (7) tick();
    chk("s4_done", 32'(done), 1);
    chk("s4_cur_sel", 32'(cur_sel), 1);
    tick();
    chk("s4_ready_idle", 32'(req_ready), 1);
    chk("s4_clk_select", 32'(clk_select), 32'h2);
    tick();
    req_valid = 1'b0;
    chk("s4_second_accept", 32'(busy), 1);
    chk("s4_second_drop", 32'(clk_select), 0);
    wait_idle();
    chk("s4_final_sel", 32'(cur_sel), 3);

    // reset in the middle of a 0 -> 3 switch
    req_valid = 1'b1; req_sel = 2'd0;
    tick();
    req_valid = 1'b0;
    wait_idle();
    req_valid = 1'b1; req_sel = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("s5_clk_select", 32'(clk_select), 0);
    chk("s5_cur_valid", 32'(cur_valid), 0);
    chk("s5_ready", 32'(req_ready), 1);
    chk("s5_busy", 32'(busy), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s5_no_done", 32'(done), 0);
    end

    // random request stream
    for (int i = 0; i < 10000; i++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!req_valid || $urandom_range(0, 7) == 0) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_sel   = 2'($urandom_range(0, NC - 1));
      end
    end
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_select_ctrl.md
CLK_SELECT_CTRL -- requirements
Module: clk_select_ctrl

Interface
REQ-001 Parameter NUM_CLOCKS, default 4: number of selectable sample clocks (2..16).
REQ-002 Parameter SEL_W, default 2: width of the binary select code; the integrator sets it to at least clog2(NUM_CLOCKS).
REQ-003 Parameter GUARD_CYCLES, default 64 (minimum 1): ctrl-clock cycles clk_select is held all-zero. It must exceed the time for 3 edges of the slowest source clock.
REQ-004 Parameter SETTLE_CYCLES, default 64 (minimum 1): ctrl-clock cycles after the new select asserts before completion is reported.
REQ-005 clk  input  1  control clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_valid  input  1  switch request valid.
REQ-008 req_sel  input  SEL_W  binary index of the requested clock.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 clk_select  output  NUM_CLOCKS  one-hot or all-zero select, registered, driving the glitch-free clock mux.
REQ-011 cur_sel  output  SEL_W  index of the currently selected clock; valid when cur_valid=1.
REQ-012 cur_valid  output  1  some clock is selected and settled.
REQ-013 busy  output  1  switch in progress.
REQ-014 done  output  1  one-cycle pulse when a switch completes.
REQ-015 err  output  1  one-cycle pulse when an accepted request is rejected.

Function
REQ-016 The FSM shall have exactly these states: IDLE, DROP, MAKE, DONE.
REQ-017 req_ready shall be 1 only in IDLE, and rst shall be 0 in that cycle.
REQ-018 A request shall be accepted on the rising edge where req_valid=1 and req_ready=1; req_sel is captured on that same edge.
REQ-019 On acceptance with req_sel >= NUM_CLOCKS:
- err=1 for the next cycle.
- State stays IDLE.
- clk_select, cur_sel and cur_valid are unchanged.
REQ-020 On acceptance with cur_valid=1 and req_sel == cur_sel: go to DONE with no change to clk_select.
REQ-021 On acceptance with cur_valid=0 (clk_select already all-zero): go directly to MAKE.
REQ-022 On acceptance of any other valid request, go to DROP:
- clk_select=0 from the next cycle.
- cur_valid=0 from the next cycle.
REQ-023 DROP shall last exactly GUARD_CYCLES cycles, then transition to MAKE.
REQ-024 On entry to MAKE, clk_select shall become 1<<req_sel.
REQ-025 MAKE shall last exactly SETTLE_CYCLES cycles, then transition to DONE.
REQ-026 DONE shall last one cycle with done=1, cur_sel=captured req_sel and cur_valid=1, then return to IDLE.
REQ-027 busy shall be 1 in DROP, MAKE and DONE, and 0 in IDLE.
REQ-028 clk_select shall never have more than one bit set.
REQ-029 clk_select shall never change directly from one nonzero value to a different nonzero value.
REQ-030 One down-counter, sized for max(GUARD_CYCLES, SETTLE_CYCLES), shall be reloaded on every state entry. It shall not wrap.
REQ-031 req_valid while not ready shall be ignored and not queued; the requester holds it until accepted.
REQ-032 Overall latency for a switch between two different clocks shall be:
- acceptance at edge T;
- clk_select=0 during cycles T+1..T+GUARD_CYCLES;
- new one-hot during T+GUARD_CYCLES+1 onward;
- done at cycle T+GUARD_CYCLES+SETTLE_CYCLES+1.

Reset
REQ-033 While rst=1 at a clock edge, the block shall take these values on the next cycle:
- state=IDLE, counter=0;
- clk_select=0, cur_sel=0, cur_valid=0;
- busy=0, done=0, err=0.
REQ-034 rst asserted in DROP or MAKE shall abort the switch.
REQ-035 After such an abort, clk_select shall be 0 from the next cycle, and no done pulse shall be issued.
REQ-036 The first request after reset shall follow REQ-021.

Verification (NUM_CLOCKS=4, SEL_W=2, GUARD_CYCLES=4, SETTLE_CYCLES=3)
REQ-037 Scenario: reset, then req_sel=2 accepted at T.
- clk_select=4'b0100 from T+1.
- done at T+4; cur_sel=2, cur_valid=1.
REQ-038 Scenario: from sel 2, req_sel=0 accepted at T.
- clk_select=0 during T+1..T+4.
- clk_select=4'b0001 from T+5.
- done at T+8; busy=1 during T+1..T+8.
REQ-039 Scenario: from sel 0, req_sel=0 accepted at T.
- done at T+1.
- clk_select stays 4'b0001 throughout.
REQ-040 Scenario: req_valid held high through a whole switch with req_sel changing.
- Only one acceptance occurs, since req_ready=0 until return to IDLE.
- The second request is accepted on the first IDLE cycle.
REQ-041 Scenario: rst=1 at T+2 of a 0->3 switch.
- clk_select=0 and cur_valid=0 from T+3.
- No done pulse.
- req_ready=1 from T+3.
REQ-042 Scenario: random request stream, 10k cycles, with a checker that enforces:
- REQ-028 and REQ-029 always hold;
- every nonzero-to-nonzero transition of clk_select has at least GUARD_CYCLES zero cycles between the two values.
